// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants and helpers for the CP0 coprocessor.
// Holds the register address map, SR/Cause bit positions, exception codes
// and the packing helpers that build the SR and Cause read views.
package cp0_pkg;

    // Register addresses (RA/WA)
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    // Bit positions inside SR / Cause
    localparam int IM_LO    = 10;   // IM/IP field occupies [15:10]
    localparam int IP_TIMER = 15;   // timer interrupt position
    localparam int EXL_BIT  = 1;
    localparam int IE_BIT   = 0;
    localparam int IM_W     = 6;    // width of the IM/IP field
    localparam int BD_BIT   = 31;
    localparam int EXC_LO   = 2;    // ExcCode occupies [6:2]

    // Exception codes loaded into Cause.ExcCode
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_MOD  = 5'd1,
        EXC_TLBL = 5'd2,
        EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_IBE  = 5'd6,
        EXC_DBE  = 5'd7,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_CPU  = 5'd11,
        EXC_OV   = 5'd12,
        EXC_TR   = 5'd13
    } exc_code_e;

    // SR read view: {16'b0, IM, 8'b0, EXL, IE}
    function automatic logic [31:0] pack_sr(input logic [IM_W-1:0] im,
                                            input logic exl,
                                            input logic ie);
        logic [31:0] sr;
        sr                 = '0;
        sr[IM_LO +: IM_W]  = im;
        sr[EXL_BIT]        = exl;
        sr[IE_BIT]         = ie;
        return sr;
    endfunction

    // Cause read view: {BD, 15'b0, IP, 3'b0, ExcCode, 2'b0}
    function automatic logic [31:0] pack_cause(input logic bd,
                                               input logic [IM_W-1:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] c;
        c                  = '0;
        c[BD_BIT]          = bd;
        c[IM_LO +: IM_W]   = ip;
        c[EXC_LO +: 5]     = exc;
        return c;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer for CP0 (only instantiated when the
// CP0_TIMER_EN macro is defined in the top).
// A prescaler divides the clock by TICK_DIV; each wrap advances Count.
// pending sets when an increment lands Count on Compare and stays set until
// Compare is written.
module cp0_timer #(
    parameter int TICK_DIV = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wd_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        pending_o
);

    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          pending_q, pending_d;
    logic          tick;
    logic [31:0]   count_inc;

    // Prescaler: free-running 0..TICK_DIV-1; a Count write never restarts it
    always_comb begin
        tick    = (presc_q == PRE_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Count/Compare/pending next state; written values beat the increment,
    // and a Compare write beats a simultaneous match
    always_comb begin
        count_inc = count_q + 32'd1;
        count_d   = count_q;
        compare_d = compare_q;
        pending_d = pending_q;

        if (count_we_i) begin
            count_d = wd_i;
        end else if (tick) begin
            count_d = count_inc;
        end

        if (compare_we_i) begin
            compare_d = wd_i;
        end

        if (compare_we_i) begin
            pending_d = 1'b0;
        end else if (tick && !count_we_i && (count_inc == compare_q)) begin
            pending_d = 1'b1;
        end
    end

    // Timer state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            pending_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            pending_q <= pending_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/cp0_param.sv
// cp0_param: parametrised CP0 (SR, Cause, EPC, PRID, optional timer).
// Optional feature macro: CP0_TIMER_EN adds Count/Compare and the timer
// interrupt on IP[15]; without it addresses 9/11 read 0 and line 5 of
// HWInt (when NUM_INT = 6) sits on bit 15.
// Update priority each cycle: ExlSet > ExlClr > WE. Whichever of the three
// is active alone takes effect; a lower-priority strobe in the same cycle
// is dropped entirely.
module cp0_param
    import cp0_pkg::*;
#(
    parameter int          NUM_INT  = 6,
    parameter int          TICK_DIV = 2,
    parameter logic [31:0] PRID_VAL = 32'h19990805
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               WE,
    input  logic               ExlSet,
    input  logic               ExlClr,
    input  logic [4:0]         RA,
    input  logic [4:0]         WA,
    input  logic [31:0]        WD,
    input  logic [31:0]        PC,
    input  logic [4:0]         ExcCode,
    input  logic               BD,
    input  logic [NUM_INT-1:0] HWInt,
    output logic               IntReq,
    output logic [31:0]        EPC,
    output logic [31:0]        RD,
    output logic               TimerInt
);

    logic [IM_W-1:0] im_q, im_d;
    logic            exl_q, exl_d;
    logic            ie_q, ie_d;
    logic            bd_q, bd_d;
    logic [4:0]      exc_q, exc_d;
    logic [31:0]     epc_q, epc_d;
    logic [IM_W-1:0] ip;
    logic            wr_en;

    // A software write only lands when no exception entry/return is active
    assign wr_en = WE & ~ExlSet & ~ExlClr;

`ifdef CP0_TIMER_EN
    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic        timer_pending;
    logic        count_we;
    logic        compare_we;

    assign count_we   = wr_en && (WA == CP0_COUNT);
    assign compare_we = wr_en && (WA == CP0_COMPARE);

    cp0_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk_i        (Clock),
        .rst_i        (Reset),
        .count_we_i   (count_we),
        .compare_we_i (compare_we),
        .wd_i         (WD),
        .count_o      (count_val),
        .compare_o    (compare_val),
        .pending_o    (timer_pending)
    );

    assign TimerInt = timer_pending;
`else
    assign TimerInt = 1'b0;
`endif

    // Live interrupt-pending view: external lines plus the timer flag
    always_comb begin
        ip = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            ip[i] = HWInt[i];
        end
`ifdef CP0_TIMER_EN
        ip[IP_TIMER - IM_LO] = timer_pending;
`endif
    end

    // Interrupt request: any enabled pending line while IE=1 and EXL=0
    always_comb begin
        IntReq = (|(im_q & ip)) & ie_q & ~exl_q;
    end

    // Next-state for SR/Cause/EPC following the ExlSet > ExlClr > WE order
    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;

        if (ExlSet) begin
            exl_d = 1'b1;
            bd_d  = BD;
            exc_d = ExcCode;
            epc_d = PC;
        end else if (ExlClr) begin
            exl_d = 1'b0;
        end else if (WE) begin
            case (WA)
                CP0_SR: begin
                    im_d  = WD[IM_LO +: IM_W];
                    exl_d = WD[EXL_BIT];
                    ie_d  = WD[IE_BIT];
                end
                CP0_CAUSE: begin
                    bd_d  = WD[BD_BIT];
                    exc_d = WD[EXC_LO +: 5];
                end
                CP0_EPC: begin
                    epc_d = WD;
                end
                default: begin
                end
            endcase
        end
    end

    // Architectural register state
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    // Read mux: combinational from registers and live IP, no WD bypass
    always_comb begin
        RD = '0;
        case (RA)
            CP0_SR:      RD = pack_sr(im_q, exl_q, ie_q);
            CP0_CAUSE:   RD = pack_cause(bd_q, ip, exc_q);
            CP0_EPC:     RD = epc_q;
            CP0_PRID:    RD = PRID_VAL;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   RD = count_val;
            CP0_COMPARE: RD = compare_val;
`endif
            default:     RD = '0;
        endcase
    end

    assign EPC = epc_q;

endmodule

// File: tb/tb_cp0_param.sv
// tb_cp0_param: self-checking bench for cp0_param (either CP0_TIMER_EN
// setting) plus a standalone cp0_timer instance with its own divider.
`timescale 1ns/1ps
module tb_cp0_param;

`ifdef CP0_TIMER_EN
    localparam int NUM_INT = 5;
`else
    localparam int NUM_INT = 6;
`endif
    localparam int          TICK_DIV = 2;
    localparam int          T_DIV    = 3;
    localparam logic [31:0] PRID     = 32'h19990805;

    // clock / reset
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    // DUT signals
    logic               WE, ExlSet, ExlClr, BD;
    logic [4:0]         RA, WA, ExcCode;
    logic [31:0]        WD, PC;
    logic [5:0]         hw;
    logic [NUM_INT-1:0] HWInt;
    logic               IntReq, TimerInt;
    logic [31:0]        EPC, RD;
    assign HWInt = hw[NUM_INT-1:0];

    // standalone timer signals
    logic        t_cw, t_pw, t_pending;
    logic [31:0] t_wd, t_count, t_compare;

    cp0_param #(.NUM_INT(NUM_INT), .TICK_DIV(TICK_DIV), .PRID_VAL(PRID)) dut (
        .Clock(Clock), .Reset(Reset), .WE(WE), .ExlSet(ExlSet), .ExlClr(ExlClr),
        .RA(RA), .WA(WA), .WD(WD), .PC(PC), .ExcCode(ExcCode), .BD(BD),
        .HWInt(HWInt), .IntReq(IntReq), .EPC(EPC), .RD(RD), .TimerInt(TimerInt)
    );

    cp0_timer #(.TICK_DIV(T_DIV)) u_tmr (
        .clk_i(Clock), .rst_i(Reset), .count_we_i(t_cw), .compare_we_i(t_pw),
        .wd_i(t_wd), .count_o(t_count), .compare_o(t_compare), .pending_o(t_pending)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] count;
        logic [31:0] compare;
        logic        pending;
        int          edges;     // clock edges since reset release
    } tmr_m_t;

    tmr_m_t      mt, ms;
    logic [5:0]  m_im;
    logic        m_exl, m_ie, m_bd;
    logic [4:0]  m_exc;
    logic [31:0] m_epc;
    int          checks = 0;
    int          errors = 0;

    // One timer edge: a tick happens on every div-th edge after reset
    function automatic tmr_m_t tmr_next(input tmr_m_t s, input int div, input logic cw,
                                        input logic pw, input logic [31:0] wd);
        tmr_m_t n;
        bit     tick;
        n       = s;
        n.edges = s.edges + 1;
        tick    = (n.edges % div) == 0;
        if (cw)        n.count = wd;
        else if (tick) n.count = 32'((64'(s.count) + 64'd1) % 64'h1_0000_0000);
        if (pw) begin
            n.compare = wd;
            n.pending = 1'b0;
        end else if (tick && !cw && (32'(s.count + 32'd1) == s.compare)) begin
            n.pending = 1'b1;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_exc = '0; m_epc = '0;
        mt.count = '0; mt.compare = '0; mt.pending = 0; mt.edges = 0;
        ms.count = '0; ms.compare = '0; ms.pending = 0; ms.edges = 0;
    endtask

    task automatic model_edge();
        logic wr;
        wr = WE && !ExlSet && !ExlClr;
        if (ExlSet) begin
            m_exl = 1; m_bd = BD; m_exc = ExcCode; m_epc = PC;
        end else if (ExlClr) begin
            m_exl = 0;
        end else if (WE) begin
            if (WA == 5'd12) begin m_im = WD[15:10]; m_exl = WD[1]; m_ie = WD[0]; end
            if (WA == 5'd13) begin m_bd = WD[31]; m_exc = WD[6:2]; end
            if (WA == 5'd14) m_epc = WD;
        end
        mt = tmr_next(mt, TICK_DIV, wr && (WA == 5'd9), wr && (WA == 5'd11), WD);
        ms = tmr_next(ms, T_DIV, t_cw, t_pw, t_wd);
    endtask

    function automatic logic [5:0] exp_ip(input logic [5:0] h);
        logic [5:0] ip;
        ip = '0;
        for (int i = 0; i < NUM_INT; i++) ip[i] = h[i];
`ifdef CP0_TIMER_EN
        ip[5] = mt.pending;
`endif
        return ip;
    endfunction

    function automatic logic exp_tint();
`ifdef CP0_TIMER_EN
        return mt.pending;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_irq(input logic [5:0] h);
        return ((m_im & exp_ip(h)) != 6'd0) && m_ie && !m_exl;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic [5:0] h);
        case (a)
            5'd12: return (32'(m_im) << 10) + (32'(m_exl) << 1) + 32'(m_ie);
            5'd13: return (32'(m_bd) << 31) + (32'(exp_ip(h)) << 10) + (32'(m_exc) << 2);
            5'd14: return m_epc;
            5'd15: return PRID;
`ifdef CP0_TIMER_EN
            5'd9:  return mt.count;
            5'd11: return mt.compare;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_rd"}, RD, exp_rd(RA, hw));
        chk({tag, "_irq"}, {31'b0, IntReq}, {31'b0, exp_irq(hw)});
        chk({tag, "_epc"}, EPC, m_epc);
        chk({tag, "_tint"}, {31'b0, TimerInt}, {31'b0, exp_tint()});
        chk({tag, "_tcnt"}, t_count, ms.count);
        chk({tag, "_tcmp"}, t_compare, ms.compare);
        chk({tag, "_tpend"}, {31'b0, t_pending}, {31'b0, ms.pending});
    endtask

    // ---------------- driver tasks ----------------
    task automatic edge_go();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic reset_assert();
        WE = 0; ExlSet = 0; ExlClr = 0; t_cw = 0; t_pw = 0; hw = '0;
        #2;
        Reset = 1;
        model_reset();
        #1;
    endtask

    task automatic reset_release();
        @(posedge Clock);
        #3;
        Reset = 0;
        edge_go();
    endtask

    task automatic chk_reset_vals(input string tag);
        logic [4:0] addrs [7];
        addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        for (int k = 0; k < 7; k++) begin
            RA = addrs[k];
            #0.5;
            chk($sformatf("%s_rd%0d", tag, addrs[k]), RD, (addrs[k] == 5'd15) ? PRID : 32'd0);
        end
        chk({tag, "_irq"}, {31'b0, IntReq}, 32'd0);
        chk({tag, "_epc"}, EPC, 32'd0);
        chk({tag, "_tint"}, {31'b0, TimerInt}, 32'd0);
        chk({tag, "_tcnt"}, t_count, 32'd0);
    endtask

    task automatic drv_write(input logic [4:0] a, input logic [31:0] d);
        WE = 1; WA = a; WD = d;
        #1;
        chk_all("wr");
        edge_go();
        WE = 0;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic        we, es, ec;
        logic [4:0]  wa;
        logic [31:0] wd, pc;
        logic [4:0]  exc;
        logic        bd;
        logic [5:0]  hw;
        logic [4:0]  ra;
        logic [31:0] e_rd;
        logic        e_irq;
        logic [31:0] e_epc;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic es, input logic ec,
                                input logic [4:0] wa, input logic [31:0] wd,
                                input logic [31:0] pc, input logic [4:0] exc, input logic bd,
                                input logic [5:0] h, input logic [4:0] ra,
                                input logic [31:0] e_rd, input logic e_irq,
                                input logic [31:0] e_epc);
        vec_t v;
        v.we = we; v.es = es; v.ec = ec; v.wa = wa; v.wd = wd; v.pc = pc;
        v.exc = exc; v.bd = bd; v.hw = h; v.ra = ra;
        v.e_rd = e_rd; v.e_irq = e_irq; v.e_epc = e_epc;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v, input int idx);
        WE = v.we; ExlSet = v.es; ExlClr = v.ec; WA = v.wa; WD = v.wd;
        PC = v.pc; ExcCode = v.exc; BD = v.bd; hw = v.hw; RA = v.ra;
        edge_go();
        WE = 0; ExlSet = 0; ExlClr = 0;
        #1;
        chk($sformatf("vec%0d_rd", idx), RD, v.e_rd);
        chk($sformatf("vec%0d_irq", idx), {31'b0, IntReq}, {31'b0, v.e_irq});
        chk($sformatf("vec%0d_epc", idx), EPC, v.e_epc);
    endtask

    vec_t vt [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic       seen;
        int         n;
        logic [4:0] wal [8];
        wal = '{5'd3, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};

        WE = 0; ExlSet = 0; ExlClr = 0; BD = 0; RA = '0; WA = '0; ExcCode = '0;
        WD = '0; PC = '0; hw = '0; t_cw = 0; t_pw = 0; t_wd = '0;
        model_reset();

        // power-on reset
        #3;
        chk_reset_vals("por");
        reset_release();

        // directed table
        vt[0]  = mk(1,0,0, 5'd12, 32'h0000_0401, 0, 0, 0, 6'h00, 5'd12, 32'h0000_0401, 0, 32'h0);
        vt[1]  = mk(0,0,0, 5'd0,  32'h0,         0, 0, 0, 6'h01, 5'd13, 32'h0000_0400, 1, 32'h0);
        vt[2]  = mk(0,1,0, 5'd0,  32'h0, 32'h3010, 0, 1, 6'h01, 5'd13, 32'h8000_0400, 0, 32'h3010);
        vt[3]  = mk(0,0,0, 5'd0,  32'h0,         0, 0, 0, 6'h01, 5'd12, 32'h0000_0403, 0, 32'h3010);
        vt[4]  = mk(0,0,1, 5'd0,  32'h0,         0, 0, 0, 6'h01, 5'd12, 32'h0000_0401, 1, 32'h3010);
        vt[5]  = mk(1,1,0, 5'd14, 32'hDEAD_BEEF, 32'h4000, 5'd12, 0, 6'h01, 5'd14, 32'h4000, 0, 32'h4000);
        vt[6]  = mk(0,0,0, 5'd0,  32'h0,         0, 0, 0, 6'h01, 5'd13, 32'h0000_0430, 0, 32'h4000);
        vt[7]  = mk(1,0,0, 5'd15, 32'h0,         0, 0, 0, 6'h01, 5'd15, PRID,          0, 32'h4000);
        vt[8]  = mk(1,0,0, 5'd13, 32'hFFFF_FFFF, 0, 0, 0, 6'h00, 5'd13, 32'h8000_007C, 0, 32'h4000);
        vt[9]  = mk(1,0,0, 5'd3,  32'hFFFF_FFFF, 0, 0, 0, 6'h00, 5'd3,  32'h0,         0, 32'h4000);
        vt[10] = mk(0,0,1, 5'd0,  32'h0,         0, 0, 0, 6'h01, 5'd12, 32'h0000_0401, 1, 32'h4000);
        vt[11] = mk(1,0,0, 5'd14, 32'h1234_5678, 0, 0, 0, 6'h01, 5'd14, 32'h1234_5678, 1, 32'h1234_5678);
        vt[12] = mk(1,0,0, 5'd12, 32'h0000_FC00, 0, 0, 0, 6'h3F, 5'd12, 32'h0000_FC00, 0, 32'h1234_5678);
        vt[13] = mk(1,0,0, 5'd12, 32'hFFFF_FFFF, 0, 0, 0, 6'h3F, 5'd12, 32'h0000_FC03, 0, 32'h1234_5678);
        vt[14] = mk(0,0,1, 5'd0,  32'h0,         0, 0, 0, 6'h10, 5'd13, 32'h8000_407C, 1, 32'h1234_5678);
        vt[15] = mk(1,0,0, 5'd13, 32'h0,         0, 0, 0, 6'h10, 5'd13, 32'h0000_4000, 1, 32'h1234_5678);
        for (int i = 0; i < 16; i++) apply_vec(vt[i], i);

        // HWInt to IntReq with no clock edge in between (IM all set, IE=1)
        hw = 6'h00;
        #1;
        chk("hw_lat_lo", {31'b0, IntReq}, 32'd0);
        hw = 6'h01;
        #1;
        chk("hw_lat_hi", {31'b0, IntReq}, 32'd1);

`ifndef CP0_TIMER_EN
        // without the timer, Count/Compare are absent
        drv_write(5'd9, 32'hFFFF_FFFF);
        drv_write(5'd11, 32'hFFFF_FFFF);
        RA = 5'd9;  #0.5; chk("notmr_rd9", RD, 32'd0);
        RA = 5'd11; #0.5; chk("notmr_rd11", RD, 32'd0);
`endif

        // asynchronous reset in the middle of an exception
        ExlSet = 1; PC = 32'h5550; ExcCode = 5'd10; BD = 1;
        edge_go();
        ExlSet = 0;
        RA = 5'd12; #0.5;
        chk("pre_rst_exl", RD, 32'h0000_FC03);
        reset_assert();
        chk_reset_vals("arst");
        reset_release();

`ifdef CP0_TIMER_EN
        // timer match drives TimerInt and IntReq
        drv_write(5'd11, 32'd5);
        drv_write(5'd9, 32'd0);
        drv_write(5'd12, 32'h0000_8001);
        RA = 5'd9; seen = 0; n = 0;
        while (!seen && n < 40) begin
            #1; chk_all("tmr");
            seen = TimerInt; n++;
            if (!seen) edge_go();
        end
        chk("tmr_rise", {31'b0, seen}, 32'd1);
        chk("tmr_irq", {31'b0, IntReq}, 32'd1);
        drv_write(5'd11, 32'd100);
        #1; chk("tmr_clr", {31'b0, TimerInt}, 32'd0);
        // Count wrap
        drv_write(5'd11, 32'd0);
        drv_write(5'd9, 32'hFFFF_FFFF);
        seen = 0; n = 0;
        while (!seen && n < 8) begin
            #1; chk_all("wrap");
            seen = TimerInt; n++;
            if (!seen) edge_go();
        end
        chk("wrap_tint", {31'b0, TimerInt}, 32'd1);
        chk("wrap_cnt", RD, 32'd0);
`endif

        // standalone timer: wrap to zero raises pending
        t_pw = 1; t_wd = 32'd0; edge_go(); t_pw = 0;
        t_cw = 1; t_wd = 32'hFFFF_FFFF; edge_go(); t_cw = 0;
        seen = 0; n = 0;
        while (!seen && n < 8) begin
            #1; chk_all("twrap");
            seen = t_pending; n++;
            if (!seen) edge_go();
        end
        chk("twrap_cnt", t_count, 32'd0);
        chk("twrap_pend", {31'b0, t_pending}, 32'd1);
        // Count write on a tick edge: write wins, prescaler keeps its phase
        n = 0;
        while (((ms.edges + 1) % T_DIV) != 0 && n < 8) begin edge_go(); n++; end
        t_cw = 1; t_wd = 32'h55; edge_go(); t_cw = 0;
        chk("tcoll_cnt", t_count, 32'h55);
        for (int k = 0; k < T_DIV - 1; k++) edge_go();
        chk("tcoll_hold", t_count, 32'h55);
        edge_go();
        chk("tcoll_next", t_count, 32'h56);
        // Compare write clears pending
        t_pw = 1; t_wd = 32'd100; edge_go(); t_pw = 0;
        chk("tclr_pend", {31'b0, t_pending}, 32'd0);

        // standalone timer random
        for (int i = 0; i < 300; i++) begin
            t_cw = ($urandom_range(0, 5) == 0);
            t_pw = ($urandom_range(0, 5) == 0);
            t_wd = ms.count + $urandom_range(0, 4);
            #1; chk_all("trnd");
            edge_go();
        end
        t_cw = 0; t_pw = 0;

        // top-level random
        for (int i = 0; i < 400; i++) begin
            WE      = ($urandom_range(0, 2) == 0);
            ExlSet  = ($urandom_range(0, 7) == 0);
            ExlClr  = ($urandom_range(0, 5) == 0);
            WA      = wal[$urandom_range(0, 7)];
            RA      = wal[$urandom_range(0, 7)];
            WD      = $urandom;
            if (WA == 5'd11 || WA == 5'd9) WD = mt.count + $urandom_range(0, 4);
            PC      = $urandom;
            ExcCode = 5'($urandom_range(0, 31));
            BD      = 1'($urandom_range(0, 1));
            hw      = 6'($urandom_range(0, 63));
            #1; chk_all("rnd");
            edge_go();
        end
        WE = 0; ExlSet = 0; ExlClr = 0;
        #1; chk_all("end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_param.md
# cp0_param

Parametrised system-control coprocessor for the pipelined MIPS core: holds SR, Cause, EPC and PRID, plus an optional Count/Compare timer that raises an internal interrupt. Interrupt width, timer tick rate and PRID value are configurable. It sits beside the M stage: the exception controller drives ExlSet/ExlClr, `mtc0`/`mfc0` use WE/WA/WD and RA/RD, and NPC takes EPC for `eret`.

## Interface
Parameters:
- NUM_INT, 6: external hardware interrupt lines, range 1..5 when the timer is compiled in, 1..6 otherwise.
- TICK_DIV, 2: Clock cycles per Count increment, at least 1.
- PRID_VAL, 32'h19990805: read-only processor ID.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high.
- WE  in  1  CP0 write enable (`mtc0`).
- ExlSet  in  1  exception/interrupt entry.
- ExlClr  in  1  `eret`.
- RA  in  5  read register address.
- WA  in  5  write register address.
- WD  in  32  write data.
- PC  in  32  victim PC, captured into EPC.
- ExcCode  in  5  exception code, captured into Cause[6:2].
- BD  in  1  branch-delay flag, captured into Cause[31].
- HWInt  in  NUM_INT  external interrupt levels.
- IntReq  out  1  interrupt request to the exception controller.
- EPC  out  32  EPC register value.
- RD  out  32  read data.
- TimerInt  out  1  timer pending flag, for debug and LEDs.

## Operation
- Register map (RA/WA):
  - 9 Count.
  - 11 Compare.
  - 12 SR = {16'b0, IM[15:10], 8'b0, EXL, IE}.
  - 13 Cause = {BD, 15'b0, IP[15:10], 3'b0, ExcCode, 2'b0}.
  - 14 EPC.
  - 15 PRID.
  - Any other address reads 0; writes to it are ignored.
- Interrupt bit mapping:
  - External line i maps to IM/IP bit 10+i.
  - The timer maps to bit 15.
  - Unused IP bits read 0.
- IP is live: IP[10+i] = HWInt[i] and IP[15] = timer_pending, sampled combinationally, not stored.
- IntReq = |(IM & IP) & IE & ~EXL.
- Update priority per cycle is ExlSet > ExlClr > WE.
  - ExlSet: EXL←1, BD←BD, ExcCode←ExcCode, EPC←PC.
  - ExlClr: EXL←0 only.
- WE writes:
  - SR: IM, EXL and IE are written.
  - Cause: only BD and ExcCode are written; IP is read-only.
  - EPC: full 32 bits.
  - PRID: ignored.
  - Count/Compare: full 32 bits.
- Timer:
  - A prescaler counts 0..TICK_DIV-1; Count increments when the prescaler wraps.
  - Count wraps 32'hFFFFFFFF→0.
  - timer_pending sets on the edge where an increment makes Count equal Compare. It is sticky.
  - Only a Compare write clears it.
  - A Count write that makes Count equal Compare does not set it.
- Count runs regardless of EXL and IE.
- Simultaneous events:
  - Count write and tick in the same cycle: the written value wins, the increment is dropped, and the prescaler is not reset.
  - Compare write and match in the same cycle: the clear wins.
  - ExlSet with WE in the same cycle: the write is dropped, including Count/Compare writes.

## Timing
- RD, IntReq and EPC are combinational from registers; RD and IntReq also depend on HWInt.
- A register written at edge N is visible on RD after edge N; no internal bypass of WD to RD.
- HWInt reaches IntReq in 0 cycles.
- Timer match to IntReq: 1 edge.
- Reset (asynchronous, any time, including mid-exception) clears:
  - IM, EXL, IE, BD, ExcCode and EPC.
  - Count, Compare, the prescaler and timer_pending.
- Reset values: IntReq=0, EPC=0, TimerInt=0. RD=0 for all addresses except PRID_VAL at 15 and live IP bits in Cause.

## Configuration
- CP0_TIMER_EN defined:
  - Count, Compare, the prescaler and timer_pending exist.
  - Bit 15 is the timer interrupt.
- CP0_TIMER_EN undefined:
  - Addresses 9 and 11 read 0 and ignore writes.
  - IP[15]=0 and TimerInt is tied to 0.
  - NUM_INT may be 6, with line 5 at bit 15.

## Structure
- Shared package cp0_pkg holds:
  - Address constants CP0_COUNT=9, CP0_COMPARE=11, CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15.
  - Bit positions IM_LO=10, IP_TIMER=15, EXL_BIT=1, IE_BIT=0.
  - ExcCode values.
- Sub-module cp0_timer holds the prescaler, Count, Compare and the pending flag. It takes write strobes and WD and outputs Count, Compare and pending.

## Test plan
- Reset mid-operation: assert Reset asynchronously with EXL=1, Count=7 → all registers 0 immediately; RD@15=32'h19990805; IntReq=0.
- Write SR=32'h0000_0401, raise HWInt[0] → IntReq=1 same cycle. Pulse ExlSet with PC=32'h3010, ExcCode=0, BD=1 → EPC=32'h3010, Cause[31]=1, IntReq=0. ExlClr → IntReq=1 again.
- Timer: TICK_DIV=2, write Compare=5, Count=0, SR=32'h0000_8001 → TimerInt and IntReq rise after the 10th edge. Write Compare=100 → TimerInt=0 next cycle.
- Count wrap: write Count=32'hFFFFFFFF, Compare=0 → after one tick Count=0 and TimerInt=1.
- Same-cycle collisions:
  - ExlSet and WE to EPC together → EPC=PC, WD discarded.
  - Count write coinciding with a tick → Count=WD.
- Writes to PRID, to IP bits and to address 3 → readback unchanged or 0. Build without CP0_TIMER_EN → RD@9=0 and RD@11=0.
